tof_i2c_arbiter: RTL

//  Round-robin arbiter that shares one I2C_Entity transaction engine between N ToF_FSM requesters.

---
 rtl/tof_i2c_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tof_i2c_arbiter.sv
// ----------------------------------------------------------------------------
// tof_i2c_arbiter
//
// Round-robin arbiter that lets N_REQ ToF_FSM requesters share one I2C_Entity
// transaction engine. A winning requester's command is latched and issued to
// the engine. The engine's ready line is tracked until the transaction ends,
// and done/err is returned to the owner. A watchdog aborts any transaction
// the engine never finishes.
//
// Handshakes:
//   requester side: req[i] is a level. It is sampled only in IDLE and is held
//     by the requester until done[i] pulses for one cycle. err[i] is valid
//     only in that cycle. A req still high in the cycle after done is a new
//     request.
//   engine side: i2c_start pulses for one cycle with the command fields
//     stable. The engine drops i2c_ready while busy and raises it again when
//     it has finished. i2c_error is sampled in the cycle ready is seen high.
//     i2c_abort pulses for one cycle to reset a hung engine.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req*            per-requester request level and packed command fields
//   done, err       one-hot completion pulse and its error flag
//   grant_valid     a transaction is owned (ISSUE..TIMEOUT)
//   grant_idx       current/last owner, drives the top-level SCL/SDA mux
//   i2c_*           engine command, start, ready/error, abort
//   fsm_state       debug view of the controller state
// ----------------------------------------------------------------------------
module tof_i2c_arbiter #(
  parameter int N_REQ       = 8,
  parameter int ADDR_W      = 16,
  parameter int NB_W        = 10,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*7-1:0]        req_slave_addr,
  input  logic [N_REQ*ADDR_W-1:0]   req_reg_addr,
  input  logic [N_REQ-1:0]          req_is_read,
  input  logic [N_REQ*NB_W-1:0]     req_nb_bytes,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic                      grant_valid,
  output logic [2:0]                grant_idx,
  output logic                      i2c_start,
  output logic [6:0]                i2c_slave_addr,
  output logic [ADDR_W-1:0]         i2c_reg_addr,
  output logic                      i2c_is_read,
  output logic [NB_W-1:0]           i2c_nb_bytes,
  input  logic                      i2c_ready,
  input  logic                      i2c_error,
  output logic                      i2c_abort,
  output logic [2:0]                fsm_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_TIMEOUT   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      rr_ptr;
  logic [TW-1:0]   timer;
  logic            err_q;
  logic            timeout_hit;

  logic [7:0]        req_ext;
  logic [2:0]        cand;
  logic              pick_found;
  logic [2:0]        pick_idx;
  logic [6:0]        sel_sa;
  logic [ADDR_W-1:0] sel_ra;
  logic              sel_rd;
  logic [NB_W-1:0]   sel_nb;
  logic [2:0]        rr_next;

  assign timeout_hit = (timer == TW'(TIMEOUT_CYC - 1));
  assign rr_next     = (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
  assign fsm_state   = state_q;

  // Round-robin search: first set bit at rr_ptr, rr_ptr+1, ... mod N_REQ.
  always_comb begin
    req_ext    = 8'(req);
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(rr_ptr) + i >= N_REQ) cand = 3'(int'(rr_ptr) + i - N_REQ);
      else                           cand = 3'(int'(rr_ptr) + i);
      if (!pick_found && req_ext[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Command mux for the picked requester; only constant slices are used.
  always_comb begin
    sel_sa = '0;
    sel_ra = '0;
    sel_rd = 1'b0;
    sel_nb = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == 3'(i)) begin
        sel_sa = req_slave_addr[i*7 +: 7];
        sel_ra = req_reg_addr[i*ADDR_W +: ADDR_W];
        sel_rd = req_is_read[i];
        sel_nb = req_nb_bytes[i*NB_W +: NB_W];
      end
    end
  end

  // Next-state logic. A ready rise beats a same-cycle watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pick_found) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!i2c_ready)       state_d = S_WAIT_DONE;
        else if (timeout_hit) state_d = S_TIMEOUT;
      end
      S_WAIT_DONE: begin
        if (i2c_ready)        state_d = S_DONE;
        else if (timeout_hit) state_d = S_TIMEOUT;
      end
      S_TIMEOUT:   state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rr_ptr         <= '0;
      timer          <= '0;
      err_q          <= 1'b0;
      grant_idx      <= '0;
      i2c_slave_addr <= '0;
      i2c_reg_addr   <= '0;
      i2c_is_read    <= 1'b0;
      i2c_nb_bytes   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_idx      <= pick_idx;
            i2c_slave_addr <= sel_sa;
            i2c_reg_addr   <= sel_ra;
            i2c_is_read    <= sel_rd;
            i2c_nb_bytes   <= sel_nb;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          err_q <= 1'b0;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          timer <= timer + TW'(1);
          if (state_d == S_TIMEOUT)
            err_q <= 1'b1;
          else if (state_q == S_WAIT_DONE && i2c_ready)
            err_q <= i2c_error;
        end
        S_DONE:  rr_ptr <= rr_next;
        default: ;
      endcase
    end
  end

  // Decoded outputs; all are zero in IDLE, which is the reset state.
  always_comb begin
    grant_valid = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) ||
                  (state_q == S_WAIT_DONE) || (state_q == S_TIMEOUT);
    i2c_start   = (state_q == S_ISSUE);
    i2c_abort   = (state_q == S_TIMEOUT);
    done        = '0;
    err         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      done[i] = (state_q == S_DONE) && (grant_idx == 3'(i));
      err[i]  = (state_q == S_DONE) && (grant_idx == 3'(i)) && err_q;
    end
  end

endmodule
